// File: rtl/text_video_out.sv
// PC-8001 80x25 text-mode pixel generator: VRAM/font fetch pipeline with 5-cycle latency and matching sync delay.
// Optional hardware blinking block cursor enabled by defining TEXT_CURSOR_EN.
module text_video_out #(
  parameter int unsigned H_ACT = 640,
  parameter int unsigned V_TOP = 40,
  parameter int unsigned V_ACT = 400,
  parameter int unsigned COLS  = 80
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [9:0]  H_CNT,
  input  logic [9:0]  V_CNT,
  input  logic        HS_IN,
  input  logic        VS_IN,
  output logic [10:0] VRAM_ADDR,
  input  logic [7:0]  VRAM_DATA,
  output logic [10:0] FONT_ADDR,
  input  logic [7:0]  FONT_DATA,
  input  logic [2:0]  FG_COLOR,
  input  logic [6:0]  CUR_X,
  input  logic [4:0]  CUR_Y,
  output logic        VGA_R,
  output logic        VGA_G,
  output logic        VGA_B,
  output logic        HS_OUT,
  output logic        VS_OUT,
  output logic        DE
);

  logic        w_hact;
  logic        w_vact;
  logic        w_act;
  logic [9:0]  w_diff;
  logic [4:0]  w_row;
  logic [2:0]  w_grow;
  logic [6:0]  w_col;
  logic [2:0]  w_pix;
  logic [10:0] w_addr;
  logic        w_pixel;
  logic        w_unused;

  logic        r_act_d1, r_act_d2, r_act_d3, r_act_d4;
  logic [2:0]  r_grow_d1, r_grow_d2;
  logic [2:0]  r_pix_d1, r_pix_d2, r_pix_d3, r_pix_d4;
  logic [3:0]  r_hs_sr;
  logic [3:0]  r_vs_sr;

  assign w_hact = H_CNT < 10'(H_ACT);
  assign w_vact = (V_CNT >= 10'(V_TOP)) && (V_CNT < 10'(V_TOP + V_ACT));
  assign w_act  = w_hact && w_vact;
  assign w_diff = V_CNT - 10'(V_TOP);
  assign w_row  = w_diff[8:4];
  assign w_grow = w_diff[3:1];
  assign w_col  = H_CNT[9:3];
  assign w_pix  = H_CNT[2:0];

  // row*80 built from two shifted copies of the row to avoid a multiplier
  assign w_addr = (COLS == 80)
                ? ({w_row, 6'b0} + {2'b0, w_row, 4'b0} + {4'b0, w_col})
                : 11'(w_row * COLS + w_col);

`ifdef TEXT_CURSOR_EN
  logic       w_cur;
  logic       r_cur_d1, r_cur_d2, r_cur_d3, r_cur_d4;
  logic       r_vs_prev;
  logic [4:0] r_frame;

  assign w_cur    = w_act && (w_row == CUR_Y) && (w_col == CUR_X);
  assign w_pixel  = FONT_DATA[~r_pix_d4] ^ (r_cur_d4 & ~r_frame[4]);
  assign w_unused = ^{w_diff[9], w_diff[0]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cur_d1  <= 1'b0;
      r_cur_d2  <= 1'b0;
      r_cur_d3  <= 1'b0;
      r_cur_d4  <= 1'b0;
      r_vs_prev <= 1'b0;
      r_frame   <= '0;
    end else begin
      r_cur_d1  <= w_cur;
      r_cur_d2  <= r_cur_d1;
      r_cur_d3  <= r_cur_d2;
      r_cur_d4  <= r_cur_d3;
      r_vs_prev <= VS_IN;
      if (r_vs_prev && !VS_IN)
        r_frame <= r_frame + 5'd1;
    end
  end
`else
  assign w_pixel  = FONT_DATA[~r_pix_d4];
  assign w_unused = ^{w_diff[9], w_diff[0], CUR_X, CUR_Y};
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      VRAM_ADDR <= '0;
      FONT_ADDR <= '0;
      r_act_d1  <= 1'b0;
      r_act_d2  <= 1'b0;
      r_act_d3  <= 1'b0;
      r_act_d4  <= 1'b0;
      r_grow_d1 <= '0;
      r_grow_d2 <= '0;
      r_pix_d1  <= '0;
      r_pix_d2  <= '0;
      r_pix_d3  <= '0;
      r_pix_d4  <= '0;
      r_hs_sr   <= '1;
      r_vs_sr   <= '1;
      VGA_R     <= 1'b0;
      VGA_G     <= 1'b0;
      VGA_B     <= 1'b0;
      DE        <= 1'b0;
      HS_OUT    <= 1'b1;
      VS_OUT    <= 1'b1;
    end else begin
      VRAM_ADDR <= w_act ? w_addr : '0;
      r_act_d1  <= w_act;
      r_act_d2  <= r_act_d1;
      r_act_d3  <= r_act_d2;
      r_act_d4  <= r_act_d3;
      r_grow_d1 <= w_grow;
      r_grow_d2 <= r_grow_d1;
      r_pix_d1  <= w_pix;
      r_pix_d2  <= r_pix_d1;
      r_pix_d3  <= r_pix_d2;
      r_pix_d4  <= r_pix_d3;
      FONT_ADDR <= {VRAM_DATA, r_grow_d2};
      // Syncs take four stages here plus the output flop: same depth as the pixel path
      r_hs_sr   <= {r_hs_sr[2:0], HS_IN};
      r_vs_sr   <= {r_vs_sr[2:0], VS_IN};
      HS_OUT    <= r_hs_sr[3];
      VS_OUT    <= r_vs_sr[3];
      VGA_R     <= r_act_d4 & w_pixel & FG_COLOR[2];
      VGA_G     <= r_act_d4 & w_pixel & FG_COLOR[1];
      VGA_B     <= r_act_d4 & w_pixel & FG_COLOR[0];
      DE        <= r_act_d4;
    end
  end

endmodule

// File: tb/tb_text_video_out.sv
// Scoreboard bench for text_video_out: a text-mode reference model queues expected outputs, a monitor checks them.
module tb_text_video_out;

  logic        CLK = 1'b0;
  logic        RST;
  logic [9:0]  H_CNT, V_CNT;
  logic        HS_IN, VS_IN;
  logic [10:0] VRAM_ADDR, FONT_ADDR;
  logic [7:0]  VRAM_DATA, FONT_DATA;
  logic [2:0]  FG_COLOR;
  logic [6:0]  CUR_X;
  logic [4:0]  CUR_Y;
  logic        VGA_R, VGA_G, VGA_B, HS_OUT, VS_OUT, DE;

  text_video_out #(.H_ACT(640), .V_TOP(40), .V_ACT(400), .COLS(80)) dut (
    .CLK(CLK), .RST(RST), .H_CNT(H_CNT), .V_CNT(V_CNT), .HS_IN(HS_IN), .VS_IN(VS_IN),
    .VRAM_ADDR(VRAM_ADDR), .VRAM_DATA(VRAM_DATA), .FONT_ADDR(FONT_ADDR), .FONT_DATA(FONT_DATA),
    .FG_COLOR(FG_COLOR), .CUR_X(CUR_X), .CUR_Y(CUR_Y),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .HS_OUT(HS_OUT), .VS_OUT(VS_OUT), .DE(DE)
  );

  always #5 CLK = ~CLK;

  logic [7:0] vram [2048];
  logic [7:0] font [2048];
  always @(posedge CLK) begin
    VRAM_DATA <= vram[VRAM_ADDR];
    FONT_DATA <= font[FONT_ADDR];
  end

  typedef struct { int c; logic [10:0] v; } addr_e_t;
  typedef struct { int c; logic [2:0] rgb; logic de; logic hs; logic vs; } pix_e_t;

  addr_e_t q_va[$];
  addr_e_t q_fa[$];
  pix_e_t  q_pix[$];

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int m_frame = 0;
  logic m_prev_vs = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // Drive one cycle of inputs and queue what the display should show for it.
  task automatic step(input logic rst, input int h, input int v, input logic hs, input logic vs);
    bit act;
    int line, row, grow, col, pix, addr, fa;
    logic [7:0] code, bits;
    logic p;
    @(posedge CLK); #1;
    RST = rst; H_CNT = 10'(h); V_CNT = 10'(v); HS_IN = hs; VS_IN = vs;
    if (rst) begin
      q_va.delete(); q_fa.delete(); q_pix.delete();
      m_frame = 0; m_prev_vs = 1'b0;
      q_va.push_back('{cyc, 11'd0});
      q_fa.push_back('{cyc, 11'd0});
      q_pix.push_back('{cyc, 3'b000, 1'b0, 1'b1, 1'b1});
    end else begin
      if (m_prev_vs && !vs) m_frame = (m_frame + 1) % 32;
      m_prev_vs = vs;
      act  = (h < 640) && (v >= 40) && (v < 440);
      line = (v - 40 + 1024) % 512;
      row  = line / 16;
      grow = (line / 2) % 8;
      col  = h / 8;
      pix  = h % 8;
      addr = act ? row * 80 + col : 0;
      code = vram[addr];
      fa   = int'(code) * 8 + grow;
      bits = font[fa];
      p    = act && bits[7 - pix];
`ifdef TEXT_CURSOR_EN
      if (act && row == int'(CUR_Y) && col == int'(CUR_X) && m_frame < 16) p = ~p;
`endif
      q_va.push_back('{cyc + 1, 11'(addr)});
      q_fa.push_back('{cyc + 3, 11'(fa)});
      q_pix.push_back('{cyc + 5, p ? FG_COLOR : 3'b000, act, hs, vs});
    end
  endtask

  always @(negedge CLK) begin
    addr_e_t a;
    pix_e_t  e;
    while (q_va.size() > 0 && q_va[0].c < cyc) begin a = q_va.pop_front(); chk("va_missed", 16'(a.c), 16'(cyc)); end
    while (q_fa.size() > 0 && q_fa[0].c < cyc) begin a = q_fa.pop_front(); chk("fa_missed", 16'(a.c), 16'(cyc)); end
    while (q_pix.size() > 0 && q_pix[0].c < cyc) begin e = q_pix.pop_front(); chk("pix_missed", 16'(e.c), 16'(cyc)); end
    if (q_va.size() > 0 && q_va[0].c == cyc) begin
      a = q_va.pop_front();
      chk("vram_addr", 16'(VRAM_ADDR), 16'(a.v));
    end
    if (q_fa.size() > 0 && q_fa[0].c == cyc) begin
      a = q_fa.pop_front();
      chk("font_addr", 16'(FONT_ADDR), 16'(a.v));
    end
    if (q_pix.size() > 0 && q_pix[0].c == cyc) begin
      e = q_pix.pop_front();
      chk("rgb", 16'({VGA_R, VGA_G, VGA_B}), 16'(e.rgb));
      chk("de", 16'(DE), 16'(e.de));
      chk("hs_out", 16'(HS_OUT), 16'(e.hs));
      chk("vs_out", 16'(VS_OUT), 16'(e.vs));
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 700, 0, 1'b1, 1'b1);
  endtask

  task automatic sweep_line(input int v);
    for (int h = 0; h < 800; h++)
      step(1'b0, h, v, !(h >= 656 && h < 752), !(v >= 490 && v < 492));
  endtask

  initial begin
    int k;
    RST = 1'b1; H_CNT = '0; V_CNT = '0; HS_IN = 1'b1; VS_IN = 1'b1;
    FG_COLOR = 3'b111; CUR_X = 7'd127; CUR_Y = 5'd31;
    for (int i = 0; i < 2048; i++) begin
      vram[i] = 8'($urandom);
      font[i] = 8'($urandom);
    end
    vram[0] = 8'h41;
    font[11'h208] = 8'h81;
    vram[3] = 8'h20;
    for (int g = 0; g < 8; g++) font[256 + g] = 8'h00;

    repeat (3) step(1'b1, 0, 0, 1'b1, 1'b1);

    // Character 0x41 at the top-left, glyph 0x81 on both scanlines of glyph row 0
    for (int h = 0; h < 8; h++) step(1'b0, h, 40, 1'b1, 1'b1);
    for (int h = 0; h < 8; h++) step(1'b0, h, 41, 1'b1, 1'b1);

    // Reset asserted mid-line, then released
    for (int h = 90; h < 100; h++) step(1'b0, h, 100, 1'b1, 1'b1);
    for (int h = 100; h < 103; h++) step(1'b1, h, 100, 1'b1, 1'b1);
    for (int h = 103; h < 131; h++) step(1'b0, h, 100, 1'b1, 1'b1);

    // Last active cell and first border line
    step(1'b0, 638, 439, 1'b1, 1'b1);
    step(1'b0, 639, 439, 1'b1, 1'b1);
    step(1'b0, 640, 439, 1'b1, 1'b1);
    step(1'b0, 0, 440, 1'b1, 1'b1);
    step(1'b0, 5, 440, 1'b1, 1'b1);

    // Free-running lines around the top and bottom border plus sync regions
    sweep_line(38); sweep_line(39); sweep_line(40); sweep_line(41);
    sweep_line(438); sweep_line(439); sweep_line(440); sweep_line(490);

    idle(6);
    FG_COLOR = 3'b010;
    sweep_line(200);
    idle(6);
    FG_COLOR = 3'b101;

    for (int i = 0; i < 3000; i++)
      step(1'b0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
           1'($urandom), 1'($urandom));

`ifdef TEXT_CURSOR_EN
    idle(6);
    FG_COLOR = 3'b111; CUR_X = 7'd3; CUR_Y = 5'd0;
    repeat (2) step(1'b1, 700, 0, 1'b1, 1'b1);
    for (int f = 0; f < 32; f++) begin
      for (int h = 0; h < 32; h++) step(1'b0, h, 40, 1'b1, 1'b1);
      idle(6);
      step(1'b0, 700, 0, 1'b1, 1'b0);
      step(1'b0, 700, 0, 1'b1, 1'b0);
      step(1'b0, 700, 0, 1'b1, 1'b1);
    end
`endif

    idle(2);
    k = 0;
    while ((q_va.size() + q_fa.size() + q_pix.size()) > 0 && k < 50) begin
      @(posedge CLK);
      k++;
    end
    if ((q_va.size() + q_fa.size() + q_pix.size()) > 0)
      chk("drain_timeout", 16'(q_va.size() + q_fa.size() + q_pix.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/text_video_out.md
Name: text_video_out

Overview:
- Downstream consumer of the VGA timing generator; takes its H/V counters and syncs.
- Produces PC-8001 80x25 text-mode pixels: fetches character codes from text VRAM and glyph rows from font ROM, then serialises 8 pixels per character.
- Doubles each 200-line source scanline to fill 400 VGA lines, with a top/bottom black border.
- Delays HS/VS so the syncs stay aligned with the pixel pipeline.

Parameters:
- H_ACT, 640, active pixels per line (80 columns x 8 pixels)
- V_TOP, 40, first active V_CNT line
- V_ACT, 400, active lines (25 rows x 8 scanlines x 2)
- COLS, 80, characters per text row

Ports:
- CLK  in  1  25 MHz pixel clock
- RST  in  1  asynchronous reset, active-high
- H_CNT  in  10  horizontal counter from timing generator (0..799)
- V_CNT  in  10  vertical counter from timing generator (0..524)
- HS_IN  in  1  horizontal sync from timing generator, active-low
- VS_IN  in  1  vertical sync from timing generator, active-low
- VRAM_ADDR  out  11  text VRAM character address (0..1999)
- VRAM_DATA  in  8  character code; synchronous RAM, valid 1 cycle after VRAM_ADDR
- FONT_ADDR  out  11  {char code[7:0], glyph row[2:0]}
- FONT_DATA  in  8  glyph row; synchronous ROM, valid 1 cycle after FONT_ADDR; bit7 = leftmost pixel
- FG_COLOR  in  3  {R,G,B} foreground colour (quasi-static)
- CUR_X  in  7  cursor column (0..79); used only with the optional feature
- CUR_Y  in  5  cursor row (0..24); used only with the optional feature
- VGA_R, VGA_G, VGA_B  out  1 each  pixel colour
- HS_OUT  out  1  delayed HS_IN
- VS_OUT  out  1  delayed VS_IN
- DE  out  1  data enable, aligned with VGA_R/G/B

Behaviour:
- Reset values:
  - VRAM_ADDR = 0, FONT_ADDR = 0, RGB = 0, DE = 0
  - HS_OUT = 1, VS_OUT = 1
  - all pipeline registers and the frame counter cleared
  - applies immediately, including mid-line or mid-frame.
- After reset release, outputs are valid from the 5th clock onward; no resynchronisation to frame start is required.
- Active region:
  - hact = H_CNT < H_ACT
  - vact = V_TOP <= V_CNT < V_TOP+V_ACT
  - act = hact & vact
- Scan decode, with line = V_CNT - V_TOP (9 bits):
  - char row = line[8:4]
  - glyph row = line[3:1] (each glyph row shown on 2 VGA lines)
  - col = H_CNT[9:3]
  - pix = H_CNT[2:0]
- Pipeline (t = cycle H_CNT is sampled):
  - t+1: VRAM_ADDR registered = row*COLS + col when act, else 0. The multiply is implemented as row*64 + row*16 + col, 11-bit result, no overflow for legal inputs.
  - t+2: VRAM_DATA valid.
  - t+3: FONT_ADDR registered = {VRAM_DATA, glyph row delayed 2}.
  - t+4: FONT_DATA valid.
  - t+5: pixel registered = FONT_DATA[7 - pix_d4]; RGB = FG_COLOR if pixel, else 000; DE = act_d5. RGB forced to 000 when act_d5 = 0.
- Sync path: HS_OUT = HS_IN delayed 5 cycles, VS_OUT = VS_IN delayed 5 cycles. Fixed 5-cycle latency on all outputs relative to H_CNT/V_CNT.
- Address generation and FONT_ADDR update every cycle. VRAM/ROM reads are therefore repeated 8x per character. This is required; there is no read-enable port.
- Frame counter (5 bits): increments on each VS_IN falling edge, detected against a registered copy of VS_IN. Wraps 31 -> 0.
- Boundaries:
  - H_CNT = 639 -> 640: DE drops exactly 5 cycles later.
  - V_CNT = V_TOP+V_ACT-1 is the last active line.
  - V_CNT < V_TOP makes line negative; this is masked by vact, and VRAM_ADDR stays 0.
  - Any H/V counter values are accepted; no illegal state exists.

Optional Feature:
- Macro: TEXT_CURSOR_EN.
- Defined:
  - Hardware block cursor active when char row == CUR_Y and col == CUR_X, pipelined with the pixel path.
  - The cursor inverts the pixel (pixel ^ 1) on all 8 glyph rows while frame counter bit 4 == 0 (blink period 32 frames).
  - Out-of-range CUR_X/CUR_Y never match.
- Undefined: CUR_X/CUR_Y are ignored, the frame counter may be removed, and output is identical to the defined case with the cursor off.

Test Plan:
- Reset during active line, H_CNT = 100, V_CNT = 100 -> RGB = 000, DE = 0, HS_OUT = VS_OUT = 1 while RST is high; correct output resumes 5 cycles after release.
- VRAM models code 0x41 at address 0, font row 0 = 0x81, FG_COLOR = 111; V_CNT = 40 or 41, H_CNT = 0..7 -> cycles 5..12 give RGB 111, 000 x6, 111, with DE = 1; FONT_ADDR = 0x208 at cycle 3.
- V_CNT = 439, H_CNT = 639 -> VRAM_ADDR = 24*80+79 = 1999; V_CNT = 440 -> DE = 0, VRAM_ADDR = 0.
- Free-running with the timing generator -> HS_OUT/VS_OUT equal HS_IN/VS_IN shifted exactly 5 cycles; DE high for 640 cycles/line on 400 lines/frame.
- H_CNT = 639 -> 640 transition -> DE falls at the cycle 5 clocks after H_CNT = 640 is sampled; no pixel leakage in the border.
- TEXT_CURSOR_EN: CUR_X = 3, CUR_Y = 0, blank glyph -> RGB = FG_COLOR for the 8 pixels of column 3 in frames 0..15, black in frames 16..31.
